// File: rtl/tracker_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tracker_sequencer
// Function : Pattern player that steps a 16-bit note-row memory at a
//            programmable row rate and drives the tracker's note/speed inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tracker_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [3:0]        init_speed,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [15:0]       note,
  output logic [3:0]        speed,
  output logic [ADDR_W-1:0] row,
  output logic              playing,
  output logic              row_strobe,
  output logic              loop_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = $clog2(16*TICK_DIV);

  localparam logic [1:0] EFF_SPEED = 2'd1;
  localparam logic [1:0] EFF_JUMP  = 2'd2;
  localparam logic [1:0] EFF_END   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LATCH = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [15:0]       note_q, note_d;
  logic [3:0]        speed_q, speed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        eff_q, eff_d;
  logic [2:0]        arg_q, arg_d;
  logic              row_strobe_q, row_strobe_d;
  logic              loop_done_q, loop_done_d;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       rd_data_q;
  logic [CNT_W-1:0]  row_last;

  // Pattern memory: write port is free-running; read is registered so a
  // same-cycle write to the fetched row returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) rd_data_q <= mem[row_q];
  end

  assign row_last = CNT_W'((32'(speed_q) + 32'd1) * TICK_DIV - 1);

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    note_d       = note_q;
    speed_d      = speed_q;
    cnt_d        = cnt_q;
    eff_d        = eff_q;
    arg_d        = arg_q;
    row_strobe_d = 1'b0;
    loop_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        note_d = '0;
        row_d  = '0;
        if (start) begin
          speed_d = init_speed;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        note_d       = {rd_data_q[15:2], 2'b00};
        eff_d        = rd_data_q[1:0];
        arg_d        = rd_data_q[4:2];
        if (rd_data_q[1:0] == EFF_SPEED) speed_d = {1'b0, rd_data_q[4:2]};
        cnt_d        = '0;
        row_strobe_d = 1'b1;
        state_d      = S_PLAY;
      end
      S_PLAY: begin
        if (tick_en) begin
          if (cnt_q == row_last) begin
            state_d = S_FETCH;
            if (eff_q == EFF_JUMP) begin
              row_d = ADDR_W'(arg_q);
            end else if (eff_q == EFF_END) begin
              loop_done_d = 1'b1;
              row_d       = '0;
              if (!loop_en) begin
                state_d = S_IDLE;
                note_d  = '0;
              end
            end else if (row_q == {ADDR_W{1'b1}}) begin
              row_d       = '0;
              loop_done_d = 1'b1;
            end else begin
              row_d = row_q + ADDR_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition above, including a pending start.
    if (stop) begin
      state_d      = S_IDLE;
      note_d       = '0;
      speed_d      = '0;
      row_d        = '0;
      cnt_d        = '0;
      row_strobe_d = 1'b0;
      loop_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      note_q       <= '0;
      speed_q      <= '0;
      cnt_q        <= '0;
      eff_q        <= '0;
      arg_q        <= '0;
      row_strobe_q <= 1'b0;
      loop_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      note_q       <= note_d;
      speed_q      <= speed_d;
      cnt_q        <= cnt_d;
      eff_q        <= eff_d;
      arg_q        <= arg_d;
      row_strobe_q <= row_strobe_d;
      loop_done_q  <= loop_done_d;
    end
  end

  assign note       = note_q;
  assign speed      = speed_q;
  assign row        = row_q;
  assign playing    = (state_q != S_IDLE);
  assign row_strobe = row_strobe_q;
  assign loop_done  = loop_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tracker_sequencer.sv
`default_nettype none
// Bench for tracker_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a row/countdown-level playback model.
module tb_tracker_sequencer;

  localparam int TICK_DIV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [3:0]  init_speed = 4'd0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [15:0] wr_data = 16'd0;
  logic [15:0] note;
  logic [3:0]  speed;
  logic [3:0]  row;
  logic        playing;
  logic        row_strobe;
  logic        loop_done;

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;
  logic tick_always = 1'b1;

  tracker_sequencer #(.ADDR_W(4), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .start(start), .stop(stop),
    .loop_en(loop_en), .init_speed(init_speed), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .note(note), .speed(speed),
    .row(row), .playing(playing), .row_strobe(row_strobe), .loop_done(loop_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) tick_en = tick_always ? 1'b1 : ($urandom_range(0, 2) == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Playback seen as: idle, or a 2-cycle gap before a row's note appears,
  // then a row lasting (speed+1)*TICK_DIV counted strobes.
  logic [15:0] m_mem [16];
  logic        m_active = 1'b0;
  int          m_gap = 0;
  logic [3:0]  m_row = 4'd0;
  logic [15:0] m_note = 16'd0;
  logic [15:0] m_word = 16'd0;
  logic [3:0]  m_speed = 4'd0;
  int          m_ticks = 0;
  logic        m_strobe = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_gap = 0; m_row = 0; m_note = 0; m_speed = 0; m_ticks = 0;
    end else if (stop) begin
      m_active = 1'b0; m_row = 0; m_note = 0; m_speed = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_speed = init_speed; m_row = 0; m_gap = 2;
      end
    end else if (m_gap == 2) begin
      m_word = m_mem[m_row];
      m_gap  = 1;
    end else if (m_gap == 1) begin
      m_gap    = 0;
      m_note   = {m_word[15:2], 2'b00};
      if (m_word[1:0] == 2'd1) m_speed = {1'b0, m_word[4:2]};
      m_ticks  = 0;
      m_strobe = 1'b1;
    end else if (tick_en) begin
      m_ticks++;
      if (m_ticks == (int'(m_speed) + 1) * TICK_DIV) begin
        m_gap = 2;
        case (m_word[1:0])
          2'd2: m_row = {1'b0, m_word[4:2]};
          2'd3: begin
            m_done = 1'b1;
            m_row  = 0;
            if (!loop_en) begin
              m_active = 1'b0; m_note = 0; m_gap = 0;
            end
          end
          default: begin
            if (m_row == 4'd15) begin
              m_row = 0; m_done = 1'b1;
            end else begin
              m_row = m_row + 4'd1;
            end
          end
        endcase
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("note", 32'(note), 32'(m_note));
      check("speed", 32'(speed), 32'(m_speed));
      check("row", 32'(row), 32'(m_row));
      check("playing", 32'(playing), 32'(m_active));
      check("row_strobe", 32'(row_strobe), 32'(m_strobe));
      check("loop_done", 32'(loop_done), 32'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] lin(input int r);
    return {3'd5, 3'(r), 2'd1, 3'd7, 3'd0, 2'd0};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic start_and_wait(input int limit, output int n);
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!row_strobe && n < limit);
    if (!row_strobe) check("first_strobe_timeout", 0, 1);
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!row_strobe && n < limit);
    if (!row_strobe) check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!loop_done && n < limit);
    if (!loop_done) check("loop_done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seq [5];
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_note", 32'(note), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_row", 32'(row), 0);
    check("rst_speed", 32'(speed), 0);
    check("rst_strobe", 32'(row_strobe), 0);
    check("rst_done", 32'(loop_done), 0);

    // Linear playback
    for (int r = 0; r < 16; r++) wr(r, lin(r));
    loop_en = 1'b1; init_speed = 4'd0; tick_always = 1'b1;
    start_and_wait(20, n);
    check("first_latency", 32'(n), 3);
    check("row0_note", 32'(note), 32'h0000_A1E0);
    wait_strobe(40, n);
    check("row_gap", 32'(n), 10);
    check("row1_note", 32'(note), 32'h0000_A5E0);
    check("row1_row", 32'(row), 1);
    wait_done(300);
    check("wrap_row", 32'(row), 0);
    do_stop();

    // Speed effect on row 0
    wr(0, 16'hA1ED);
    start_and_wait(20, n);
    check("spd_speed", 32'(speed), 3);
    check("spd_note", 32'(note), 32'h0000_A1EC);
    wait_strobe(80, n);
    check("spd_gap", 32'(n), 34);
    do_stop();
    wr(0, lin(0));

    // Jump from row 2 to row 6
    wr(2, 16'hA9FA);
    start_and_wait(20, n);
    seq[0] = int'(row);
    for (int k = 1; k < 5; k++) begin
      wait_strobe(40, n);
      seq[k] = int'(row);
    end
    check("jump_seq2", 32'(seq[2]), 2);
    check("jump_seq3", 32'(seq[3]), 6);
    check("jump_seq4", 32'(seq[4]), 7);
    do_stop();
    wr(2, lin(2));

    // End at row 4, looping then stopping
    wr(4, 16'hB1E3);
    loop_en = 1'b1;
    start_and_wait(20, n);
    wait_done(100);
    check("end_loop_row", 32'(row), 0);
    check("end_loop_playing", 32'(playing), 1);
    do_stop();
    loop_en = 1'b0;
    start_and_wait(20, n);
    wait_done(100);
    check("end_stop_playing", 32'(playing), 0);
    check("end_stop_note", 32'(note), 0);
    @(negedge clk);
    check("end_stop_idle", 32'(playing), 0);
    wr(4, lin(4));
    loop_en = 1'b1;

    // start+stop together while idle, then stop mid-row 3
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("collide_playing", 32'(playing), 0);
    start_and_wait(20, n);
    for (int k = 0; k < 3; k++) wait_strobe(40, n);
    check("mid_row3", 32'(row), 3);
    repeat (4) @(negedge clk);
    do_stop();
    check("stop_playing", 32'(playing), 0);
    check("stop_note", 32'(note), 0);
    check("stop_row", 32'(row), 0);

    // Live edit of row 5 during row 3
    start_and_wait(20, n);
    for (int k = 0; k < 3; k++) wait_strobe(40, n);
    wr(5, 16'h5678);
    wait_strobe(40, n);
    wait_strobe(40, n);
    check("edit_row", 32'(row), 5);
    check("edit_note", 32'(note), 32'h0000_5678);
    do_stop();
    wr(5, lin(5));

    // Reset mid-playback
    start_and_wait(20, n);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstp_note", 32'(note), 0);
    check("rstp_playing", 32'(playing), 0);
    check("rstp_row", 32'(row), 0);
    check("rstp_speed", 32'(speed), 0);
    check("rstp_strobe", 32'(row_strobe), 0);
    rst = 1'b0;

    // Random traffic
    tick_always = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      loop_en    = 1'($urandom_range(0, 1));
      init_speed = 4'($urandom_range(0, 2));
      start      = ($urandom_range(0, 15) == 0);
      stop       = ($urandom_range(0, 149) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      wr_en      = ($urandom_range(0, 7) == 0);
      wr_addr    = 4'($urandom_range(0, 15));
      wr_data    = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
